// File: rtl/fir_run_sequencer.sv
// fir_run_sequencer
// Benchmarks the two FIR implementations that share the BRAM. A rising
// edge on go runs the non-pipelined filter and then the pipelined filter.
// Each run's latency is measured in clock cycles.
//
// Parameters
//   CNT_W   : width of the cycle counters
//   TIMEOUT : cycle limit per run before it is aborted (must be < 2**CNT_W)
//   SETTLE  : idle cycles after sel_pipelined changes before start (>= 1)
// Ports
//   clk, rst      : clock; synchronous active-high reset
//   go            : launch request (rising edge)
//   done_in       : muxed done from the FIR top level
//   sel_pipelined : 0 selects the non-pipelined filter, 1 the pipelined one
//   start         : one-cycle start pulse to the FIR top level
//   busy          : sequence in progress
//   finished      : both runs completed, results valid
//   timeout_err   : a run timed out; err_run names that run
//   cycles_np     : latency of the non-pipelined run
//   cycles_p      : latency of the pipelined run
//   pipe_faster   : cycles_p < cycles_np, valid with finished
module fir_run_sequencer #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 4095,
    parameter int SETTLE  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic             done_in,
    output logic             sel_pipelined,
    output logic             start,
    output logic             busy,
    output logic             finished,
    output logic             timeout_err,
    output logic             err_run,
    output logic [CNT_W-1:0] cycles_np,
    output logic [CNT_W-1:0] cycles_p,
    output logic             pipe_faster
);

    localparam logic [CNT_W-1:0] TIMEOUT_C   = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] SETTLE_M1_C = CNT_W'(SETTLE - 1);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_SETUP_NP = 4'd1,
        S_START_NP = 4'd2,
        S_RUN_NP   = 4'd3,
        S_SETUP_P  = 4'd4,
        S_START_P  = 4'd5,
        S_RUN_P    = 4'd6,
        S_REPORT   = 4'd7,
        S_ERROR    = 4'd8
    } state_t;

    state_t           state_r;
    state_t           state_next_s;
    logic             go_prev_r;
    logic [CNT_W-1:0] settle_cnt_r;
    logic [CNT_W-1:0] run_cnt_r;
    logic [CNT_W-1:0] cycles_np_r;
    logic [CNT_W-1:0] cycles_p_r;
    logic             sel_r;
    logic             pipe_faster_r;
    logic             err_run_r;

    logic             launch_s;
    logic             settled_s;
    logic             run_tmo_s;
    logic [CNT_W-1:0] run_inc_s;

    // Launch detection and run/settle conditions shared by both processes.
    always_comb begin
        launch_s  = 1'b0;
        run_inc_s = run_cnt_r + CNT_W'(1);
        // A stale done from the previous run keeps the setup phase waiting.
        settled_s = (settle_cnt_r >= SETTLE_M1_C) && !done_in;
        run_tmo_s = !done_in && (run_inc_s == TIMEOUT_C);
        case (state_r)
            S_IDLE, S_REPORT, S_ERROR: launch_s = go && !go_prev_r;
            default:                   launch_s = 1'b0;
        endcase
    end

    // Next-state logic; a launch has priority over a done in REPORT.
    always_comb begin
        state_next_s = state_r;
        if (launch_s) begin
            state_next_s = S_SETUP_NP;
        end else begin
            case (state_r)
                S_IDLE:     state_next_s = S_IDLE;
                S_SETUP_NP: state_next_s = settled_s ? S_START_NP : S_SETUP_NP;
                S_START_NP: state_next_s = S_RUN_NP;
                S_RUN_NP: begin
                    if (done_in) begin
                        state_next_s = S_SETUP_P;
                    end else if (run_tmo_s) begin
                        state_next_s = S_ERROR;
                    end else begin
                        state_next_s = S_RUN_NP;
                    end
                end
                S_SETUP_P:  state_next_s = settled_s ? S_START_P : S_SETUP_P;
                S_START_P:  state_next_s = S_RUN_P;
                S_RUN_P: begin
                    if (done_in) begin
                        state_next_s = S_REPORT;
                    end else if (run_tmo_s) begin
                        state_next_s = S_ERROR;
                    end else begin
                        state_next_s = S_RUN_P;
                    end
                end
                S_REPORT:   state_next_s = S_REPORT;
                S_ERROR:    state_next_s = S_ERROR;
                default:    state_next_s = S_IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Counters, latched results and the filter select.
    always_ff @(posedge clk) begin
        if (rst) begin
            go_prev_r     <= 1'b0;
            settle_cnt_r  <= '0;
            run_cnt_r     <= '0;
            cycles_np_r   <= '0;
            cycles_p_r    <= '0;
            sel_r         <= 1'b0;
            pipe_faster_r <= 1'b0;
            err_run_r     <= 1'b0;
        end else begin
            go_prev_r <= go;
            if (launch_s) begin
                settle_cnt_r  <= '0;
                cycles_np_r   <= '0;
                cycles_p_r    <= '0;
                sel_r         <= 1'b0;
                pipe_faster_r <= 1'b0;
                err_run_r     <= 1'b0;
            end else begin
                case (state_r)
                    S_SETUP_NP, S_SETUP_P: begin
                        // Saturates once the settle condition is met.
                        if (settle_cnt_r < SETTLE_M1_C) begin
                            settle_cnt_r <= settle_cnt_r + CNT_W'(1);
                        end
                    end
                    S_START_NP, S_START_P: begin
                        run_cnt_r <= '0;
                    end
                    S_RUN_NP: begin
                        if (done_in) begin
                            cycles_np_r  <= run_inc_s;
                            settle_cnt_r <= '0;
                            sel_r        <= 1'b1;
                        end else if (run_tmo_s) begin
                            cycles_np_r <= TIMEOUT_C;
                            err_run_r   <= 1'b0;
                        end else begin
                            run_cnt_r <= run_inc_s;
                        end
                    end
                    S_RUN_P: begin
                        if (done_in) begin
                            cycles_p_r    <= run_inc_s;
                            pipe_faster_r <= (run_inc_s < cycles_np_r);
                        end else if (run_tmo_s) begin
                            cycles_p_r <= TIMEOUT_C;
                            err_run_r  <= 1'b1;
                        end else begin
                            run_cnt_r <= run_inc_s;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // Status outputs decoded from the state register only.
    always_comb begin
        start       = 1'b0;
        busy        = 1'b0;
        finished    = 1'b0;
        timeout_err = 1'b0;
        case (state_r)
            S_SETUP_NP, S_RUN_NP, S_SETUP_P, S_RUN_P: busy = 1'b1;
            S_START_NP, S_START_P: begin
                busy  = 1'b1;
                start = 1'b1;
            end
            S_REPORT: finished    = 1'b1;
            S_ERROR:  timeout_err = 1'b1;
            default:  busy        = 1'b0;
        endcase
    end

    assign sel_pipelined = sel_r;
    assign cycles_np     = cycles_np_r;
    assign cycles_p      = cycles_p_r;
    assign pipe_faster   = pipe_faster_r;
    assign err_run       = err_run_r;

endmodule
